// File: rtl/day5_range_engine_if.sv
// Handshake bundle for the range engine: range load channel and ID query channel.
interface day5_range_engine_if #(
  parameter int WIDTH = 64
);
  logic             range_valid;
  logic             range_ready;
  logic [WIDTH-1:0] range_start;
  logic [WIDTH-1:0] range_end;
  logic             range_last;
  logic             id_valid;
  logic             id_ready;
  logic [WIDTH-1:0] id_in;

  modport master (
    output range_valid, range_start, range_end, range_last, id_valid, id_in,
    input  range_ready, id_ready
  );

  modport slave (
    input  range_valid, range_start, range_end, range_last, id_valid, id_in,
    output range_ready, id_ready
  );
endinterface

// File: rtl/day5_range_engine.sv
// Loads inclusive ranges, merges overlapping ones pairwise, sums their covered span,
// then counts query IDs that fall inside any merged range.
module day5_range_engine #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 256,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  day5_range_engine_if.slave  bus,
  output logic [31:0]         fresh_count,
  output logic [WIDTH+CW-1:0] total_span,
  output logic [CW-1:0]       range_count,
  output logic                span_done,
  output logic                busy,
  output logic                bad_range
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {LOAD, MERGE, SUM, QUERY} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] s_mem [DEPTH];
  logic [WIDTH-1:0] e_mem [DEPTH];
  logic [DEPTH-1:0] v_mem;
  logic [AW-1:0]    mi, mj, sk;
  logic             pass_changed;

  logic             range_fire, range_bad, id_fire, id_hit;
  logic             merge_hit, pair_row_end, pass_end, sum_last;
  logic [WIDTH:0]   span_term;

  assign range_fire = bus.range_valid & bus.range_ready;
  assign id_fire    = bus.id_valid & bus.id_ready;
  assign range_bad  = bus.range_start > bus.range_end;

  // Pair (mi, mj) walks row-major; a pass ends on the last pair (count-2, count-1).
  assign merge_hit    = v_mem[mi] && v_mem[mj] &&
                        (s_mem[mi] <= e_mem[mj]) && (s_mem[mj] <= e_mem[mi]);
  assign pair_row_end = (CW'(mj) == range_count - CW'(1));
  assign pass_end     = pair_row_end && (CW'(mi) == range_count - CW'(2));
  assign sum_last     = (CW'(sk) + CW'(1) >= range_count);
  assign span_term    = {1'b0, e_mem[sk]} - {1'b0, s_mem[sk]} + (WIDTH+1)'(1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    id_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v_mem[k] && (bus.id_in >= s_mem[k]) && (bus.id_in <= e_mem[k])) id_hit = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || clear) state <= LOAD;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:  if (range_fire && bus.range_last) state_next = MERGE;
      MERGE: begin
        if (range_count <= CW'(1))                          state_next = SUM;
        else if (pass_end && !pass_changed && !merge_hit)   state_next = SUM;
      end
      SUM:   if (sum_last) state_next = QUERY;
      QUERY: state_next = QUERY;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    bus.range_ready = 1'b0;
    bus.id_ready    = 1'b0;
    busy            = 1'b0;
    case (state)
      LOAD:       bus.range_ready = (range_count < CW'(DEPTH));
      MERGE, SUM: busy = 1'b1;
      QUERY:      bus.id_ready = 1'b1;
      default:    ;
    endcase
  end

  // NOTE: range bounds are plain storage without reset; v_mem alone decides whether a slot counts.
  always_ff @(posedge clock) begin
    if (range_fire && !range_bad) begin
      s_mem[range_count[AW-1:0]] <= bus.range_start;
      e_mem[range_count[AW-1:0]] <= bus.range_end;
    end else if (state == MERGE && range_count > CW'(1) && merge_hit) begin
      if (s_mem[mj] < s_mem[mi]) s_mem[mi] <= s_mem[mj];
      if (e_mem[mj] > e_mem[mi]) e_mem[mi] <= e_mem[mj];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      range_count  <= '0;
      v_mem        <= '0;
      mi           <= '0;
      mj           <= AW'(1);
      sk           <= '0;
      pass_changed <= 1'b0;
      total_span   <= '0;
      span_done    <= 1'b0;
      bad_range    <= 1'b0;
      fresh_count  <= '0;
    end else begin
      case (state)
        LOAD: begin
          mi           <= '0;
          mj           <= AW'(1);
          sk           <= '0;
          pass_changed <= 1'b0;
          if (range_fire) begin
            if (range_bad) begin
              bad_range <= 1'b1;
            end else begin
              v_mem[range_count[AW-1:0]] <= 1'b1;
              range_count                <= range_count + CW'(1);
            end
          end
        end
        MERGE: begin
          if (range_count > CW'(1)) begin
            if (merge_hit) v_mem[mj] <= 1'b0;
            if (pass_end) begin
              mi           <= '0;
              mj           <= AW'(1);
              pass_changed <= 1'b0;
            end else begin
              pass_changed <= pass_changed | merge_hit;
              if (pair_row_end) begin
                mi <= mi + AW'(1);
                mj <= mi + AW'(2);
              end else begin
                mj <= mj + AW'(1);
              end
            end
          end
        end
        SUM: begin
          if (CW'(sk) < range_count && v_mem[sk])
            total_span <= total_span + {{(CW-1){1'b0}}, span_term};
          sk <= sk + AW'(1);
          if (sum_last) span_done <= 1'b1;
        end
        QUERY: begin
          if (id_fire && id_hit && fresh_count != '1) fresh_count <= fresh_count + 32'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_day5_range_engine.sv
// Self-checking bench for day5_range_engine: directed scenarios, an ID table and random loads.
module tb_day5_range_engine;
  localparam int W = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic clear4 = 1'b0;
  always #5 clock = ~clock;

  day5_range_engine_if #(.WIDTH(W)) bus ();
  day5_range_engine_if #(.WIDTH(W)) bus4 ();

  logic [31:0]   fresh_count, fresh_count4;
  logic [W+4:0]  total_span;
  logic [W+2:0]  total_span4;
  logic [4:0]    range_count;
  logic [2:0]    range_count4;
  logic          span_done, busy, bad_range;
  logic          span_done4, busy4, bad_range4;

  day5_range_engine #(.WIDTH(W), .DEPTH(16)) dut (
    .clock(clock), .reset(reset), .clear(clear), .bus(bus),
    .fresh_count(fresh_count), .total_span(total_span), .range_count(range_count),
    .span_done(span_done), .busy(busy), .bad_range(bad_range)
  );

  day5_range_engine #(.WIDTH(W), .DEPTH(4)) dut4 (
    .clock(clock), .reset(reset), .clear(clear4), .bus(bus4),
    .fresh_count(fresh_count4), .total_span(total_span4), .range_count(range_count4),
    .span_done(span_done4), .busy(busy4), .bad_range(bad_range4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] id;
    int           hit;
  } id_vec_t;
  id_vec_t id_tbl[6];

  // Reference state for random loads: well-formed ranges kept as plain lists.
  logic [W-1:0] ref_s[$];
  logic [W-1:0] ref_e[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic bit covered(input logic [W-1:0] v);
    foreach (ref_s[k]) if (v >= ref_s[k] && v <= ref_e[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input logic [W-1:0] s, input logic [W-1:0] e, input bit last);
    int n = 0;
    bus.range_valid = 1'b1;
    bus.range_start = s;
    bus.range_end   = e;
    bus.range_last  = last;
    while (!bus.range_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) timeout("push");
    @(negedge clock);
    bus.range_valid = 1'b0;
    bus.range_last  = 1'b0;
  endtask

  task automatic push4(input logic [W-1:0] s, input logic [W-1:0] e, input bit last);
    int n = 0;
    bus4.range_valid = 1'b1;
    bus4.range_start = s;
    bus4.range_end   = e;
    bus4.range_last  = last;
    while (!bus4.range_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) timeout("push4");
    @(negedge clock);
    bus4.range_valid = 1'b0;
    bus4.range_last  = 1'b0;
  endtask

  task automatic send_id(input logic [W-1:0] id);
    int n = 0;
    bus.id_valid = 1'b1;
    bus.id_in    = id;
    while (!bus.id_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) timeout("send_id");
    @(negedge clock);
    bus.id_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!span_done && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) timeout("wait_span_done");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_range_ready"}, bus.range_ready, 1);
    check({tag, "_id_ready"},    bus.id_ready, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_span_done"},   span_done, 0);
    check({tag, "_bad_range"},   bad_range, 0);
    check({tag, "_fresh"},       fresh_count, 0);
    check({tag, "_total"},       total_span, 0);
    check({tag, "_count"},       range_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_fresh;
    int nr, ngood;
    bit any_bad;
    logic [W-1:0] s, e, t, id;
    logic [127:0] span;

    id_tbl[0] = '{64'd1, 0};
    id_tbl[1] = '{64'd5, 1};
    id_tbl[2] = '{64'd8, 0};
    id_tbl[3] = '{64'd11, 1};
    id_tbl[4] = '{64'd17, 1};
    id_tbl[5] = '{64'd32, 0};

    bus.range_valid = 0; bus.range_start = 0; bus.range_end = 0; bus.range_last = 0;
    bus.id_valid = 0; bus.id_in = 0;
    bus4.range_valid = 0; bus4.range_start = 0; bus4.range_end = 0; bus4.range_last = 0;
    bus4.id_valid = 0; bus4.id_in = 0;

    @(negedge clock);
    check_idle("reset");
    check("reset_ready4", bus4.range_ready, 1);
    reset = 1'b0;

    // Overlap chain with an ID presented during LOAD that must not be counted.
    bus.id_valid = 1'b1;
    bus.id_in    = 64'd4;
    check("load_id_ready", bus.id_ready, 0);
    push(3, 5, 0);
    push(10, 14, 0);
    push(16, 20, 0);
    push(12, 18, 1);
    bus.id_valid = 1'b0;
    check("merge_busy", busy, 1);
    check("merge_range_ready", bus.range_ready, 0);
    wait_done();
    check("ex1_span_done", span_done, 1);
    check("ex1_total", total_span, 14);
    check("ex1_count", range_count, 4);
    check("ex1_busy", busy, 0);
    check("ex1_id_ready", bus.id_ready, 1);
    check("ex1_no_early_id", fresh_count, 0);
    exp_fresh = 0;
    for (int k = 0; k < 6; k++) begin
      send_id(id_tbl[k].id);
      exp_fresh += id_tbl[k].hit;
      check($sformatf("ex1_id_%0d", id_tbl[k].id), fresh_count, exp_fresh);
    end
    check("ex1_span_done_held", span_done, 1);

    // Reset in the middle of a multi-pass merge, then a fresh adjacent-ranges load.
    do_clear();
    push(0, 10, 0);
    push(20, 30, 0);
    push(5, 25, 0);
    push(40, 50, 0);
    push(45, 60, 1);
    @(negedge clock);
    check("mid_merge_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle("midreset");
    push(1, 2, 0);
    push(3, 4, 1);
    wait_done();
    check("adj_total", total_span, 4);
    check("adj_count", range_count, 2);
    send_id(3);
    check("adj_fresh", fresh_count, 1);

    // Malformed range is accepted but only flags bad_range.
    do_clear();
    push(9, 2, 0);
    check("bad_flag_early", bad_range, 1);
    push(1, 1, 1);
    wait_done();
    check("bad_flag", bad_range, 1);
    check("bad_count", range_count, 1);
    check("bad_total", total_span, 1);

    // Full-width ranges: span must carry into bit WIDTH.
    do_clear();
    push({W{1'b1}} & 64'd0, {W{1'b1}}, 0);
    push(0, {W{1'b1}}, 1);
    wait_done();
    check("wide_total", total_span, 128'd1 << 64);
    check("wide_count", range_count, 2);
    send_id({W{1'b1}});
    check("wide_fresh", fresh_count, 1);

    // Clear on the same edge as a range handshake discards it.
    do_clear();
    push(5, 6, 0);
    bus.range_valid = 1'b1;
    bus.range_start = 7;
    bus.range_end   = 8;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    bus.range_valid = 1'b0;
    check("clear_hs_count", range_count, 0);
    push(50, 60, 1);
    wait_done();
    check("clear_hs_total", total_span, 11);
    check("clear_hs_count2", range_count, 1);

    // DEPTH=4 instance: fifth range stalls with valid held and nothing is lost.
    for (int k = 0; k < 4; k++) push4(k * 10, k * 10 + 1, 0);
    bus4.range_valid = 1'b1;
    bus4.range_start = 40;
    bus4.range_end   = 41;
    repeat (3) @(negedge clock);
    check("full_ready", bus4.range_ready, 0);
    check("full_count", range_count4, 4);
    check("full_busy", busy4, 0);
    bus4.range_valid = 1'b0;
    @(negedge clock);
    check("full_count_held", range_count4, 4);
    clear4 = 1'b1;
    @(negedge clock);
    clear4 = 1'b0;
    for (int k = 0; k < 4; k++) push4(k * 10, k * 10 + 1, k == 3);
    for (int n = 0; n < 200 && !span_done4; n++) @(negedge clock);
    check("full_span_done", span_done4, 1);
    check("full_total", total_span4, 8);

    // Random loads against a coverage-by-enumeration model.
    for (int it = 0; it < 25; it++) begin
      if (it % 2 == 0) do_clear();
      else begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
      ref_s.delete();
      ref_e.delete();
      any_bad = 0;
      ngood = 0;
      nr = $urandom_range(1, 10);
      for (int r = 0; r < nr; r++) begin
        s = $urandom_range(0, 99);
        e = s + $urandom_range(0, 15);
        if (e != s && $urandom_range(0, 7) == 0) begin
          t = s; s = e; e = t;
          any_bad = 1;
        end else begin
          ref_s.push_back(s);
          ref_e.push_back(e);
          ngood++;
        end
        push(s, e, r == nr - 1);
      end
      wait_done();
      span = 0;
      for (int v = 0; v < 128; v++) if (covered(v)) span++;
      check($sformatf("rnd%0d_count", it), range_count, ngood);
      check($sformatf("rnd%0d_bad", it), bad_range, any_bad);
      check($sformatf("rnd%0d_total", it), total_span, span);
      exp_fresh = 0;
      for (int q = 0; q < 8; q++) begin
        id = $urandom_range(0, 127);
        if (covered(id)) exp_fresh++;
        send_id(id);
      end
      check($sformatf("rnd%0d_fresh", it), fresh_count, exp_fresh);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
